// File: rtl/branch_ctrl_if.sv
// rtl/branch_ctrl_if.sv - decoder-to-PC redirect bundle plus flag/stack status
interface branch_ctrl_if #(
  parameter int AW = 3
);
  logic          en;
  logic [2:0]    op;
  logic [3:0]    cond;
  logic [7:0]    disp8_in;
  logic [10:0]   label11_in;
  logic [15:0]   rd_val;
  logic [15:0]   rm_val;
  logic [15:0]   pc_q;
  logic          flag_we;
  logic [3:0]    nzcv_in;

  logic          JMP;
  logic          BRANCH;
  logic          flag_Rd_PC;
  logic          flag_label_PC;
  logic          flag_Rm_PC;
  logic [7:0]    disp8;
  logic [10:0]   label11;
  logic [15:0]   Rd;
  logic [15:0]   Rm;
  logic [3:0]    nzcv;
  logic [AW:0]   ras_count;
  logic          ras_ovf;
  logic          ras_unf;

  modport master (
    output en, op, cond, disp8_in, label11_in, rd_val, rm_val, pc_q, flag_we, nzcv_in,
    input  JMP, BRANCH, flag_Rd_PC, flag_label_PC, flag_Rm_PC, disp8, label11, Rd, Rm,
    input  nzcv, ras_count, ras_ovf, ras_unf
  );

  modport slave (
    input  en, op, cond, disp8_in, label11_in, rd_val, rm_val, pc_q, flag_we, nzcv_in,
    output JMP, BRANCH, flag_Rd_PC, flag_label_PC, flag_Rm_PC, disp8, label11, Rd, Rm,
    output nzcv, ras_count, ras_ovf, ras_unf
  );
endinterface

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - PC redirect generator with NZCV flags and circular return-address stack
module branch_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic         clk,
  input  logic         clr,
  branch_ctrl_if.slave b
);

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_BCOND  = 3'd1,
    OP_B      = 3'd2,
    OP_BL     = 3'd3,
    OP_BX_RD  = 3'd4,
    OP_BX_RM  = 3'd5,
    OP_RET    = 3'd6,
    OP_NOP7   = 3'd7
  } op_e;

  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] SP_ONE  = 1;

  logic [3:0]    nzcv_q, nzcv_d;
  logic [AW-1:0] sp_q, sp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];

  logic          jmp, branch, sel_rd, sel_label, sel_rm;
  logic [7:0]    disp8_o;
  logic [10:0]   label11_o;
  logic [15:0]   rd_o, rm_o;
  logic          base_hit, cond_hit;
  logic [AW-1:0] sp_top;
  op_e           op;

  assign op     = op_e'(b.op);
  assign sp_top = sp_q - SP_ONE;

  // Odd condition codes are the complement of the even code below them (AL/NV included).
  always_comb begin
    base_hit = 1'b0;
    case (b.cond[3:1])
      3'd0: base_hit = nzcv_q[2];
      3'd1: base_hit = nzcv_q[1];
      3'd2: base_hit = nzcv_q[3];
      3'd3: base_hit = nzcv_q[0];
      3'd4: base_hit = nzcv_q[1] & ~nzcv_q[2];
      3'd5: base_hit = (nzcv_q[3] == nzcv_q[0]);
      3'd6: base_hit = ~nzcv_q[2] & (nzcv_q[3] == nzcv_q[0]);
      3'd7: base_hit = 1'b1;
      default: base_hit = 1'b0;
    endcase
    cond_hit = base_hit ^ b.cond[0];
  end

  always_comb begin
    jmp       = 1'b0;
    branch    = 1'b0;
    sel_rd    = 1'b0;
    sel_label = 1'b0;
    sel_rm    = 1'b0;
    disp8_o   = '0;
    label11_o = '0;
    rd_o      = '0;
    rm_o      = '0;
    nzcv_d    = nzcv_q;
    sp_d      = sp_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    mem_d     = mem_q;

    if (b.flag_we) nzcv_d = b.nzcv_in;

    // Gating on clr keeps outputs idle and blocks stack updates during reset.
    if (clr && b.en) begin
      case (op)
        OP_BCOND: begin
          if (cond_hit) begin
            branch  = 1'b1;
            disp8_o = b.disp8_in;
          end
        end
        OP_B: begin
          jmp       = 1'b1;
          sel_label = 1'b1;
          label11_o = b.label11_in;
        end
        OP_BL: begin
          jmp         = 1'b1;
          sel_label   = 1'b1;
          label11_o   = b.label11_in;
          mem_d[sp_q] = b.pc_q + 16'd1;
          sp_d        = sp_q + SP_ONE;
          if (cnt_q == FULL) ovf_d = 1'b1;
          else               cnt_d = cnt_q + CNT_ONE;
        end
        OP_BX_RD: begin
          jmp    = 1'b1;
          sel_rd = 1'b1;
          rd_o   = b.rd_val;
        end
        OP_BX_RM: begin
          jmp    = 1'b1;
          sel_rm = 1'b1;
          rm_o   = b.rm_val;
        end
        OP_RET: begin
          if (cnt_q != '0) begin
            jmp    = 1'b1;
            sel_rd = 1'b1;
            rd_o   = mem_q[sp_top];
            sp_d   = sp_top;
            cnt_d  = cnt_q - CNT_ONE;
          end else begin
            unf_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      nzcv_q <= '0;
      sp_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      nzcv_q <= nzcv_d;
      sp_q   <= sp_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Stack contents need no reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign b.JMP           = jmp;
  assign b.BRANCH        = branch;
  assign b.flag_Rd_PC    = sel_rd;
  assign b.flag_label_PC = sel_label;
  assign b.flag_Rm_PC    = sel_rm;
  assign b.disp8         = disp8_o;
  assign b.label11       = label11_o;
  assign b.Rd            = rd_o;
  assign b.Rm            = rm_o;
  assign b.nzcv          = nzcv_q;
  assign b.ras_count     = cnt_q;
  assign b.ras_ovf       = ovf_q;
  assign b.ras_unf       = unf_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - randomized and directed bench for branch_ctrl against a queue-based model
module tb_branch_ctrl;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  branch_ctrl_if #(.AW(AW)) bif ();

  branch_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .clr (clr),
    .b   (bif.slave)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [15:0] m_stack [$];
  logic [3:0]  m_nzcv;
  bit          m_ovf, m_unf;
  bit          m_rst;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Packed as {JMP, BRANCH, Rd_PC, label_PC, Rm_PC, disp8, label11, Rd, Rm}.
  function automatic logic [55:0] pack(input bit j, br, srd, slb, srm, input logic [7:0] d8,
                                       input logic [10:0] l11, input logic [15:0] rd, rm);
    return {j, br, srd, slb, srm, d8, l11, rd, rm};
  endfunction

  function automatic logic [55:0] dut_out();
    return pack(bif.JMP, bif.BRANCH, bif.flag_Rd_PC, bif.flag_label_PC, bif.flag_Rm_PC,
                bif.disp8, bif.label11, bif.Rd, bif.Rm);
  endfunction

  function automatic logic [55:0] exp_out();
    if (m_rst || !bif.en) return '0;
    case (bif.op)
      3'd1: return cond_true(bif.cond, m_nzcv) ? pack(0, 1, 0, 0, 0, bif.disp8_in, 0, 0, 0) : '0;
      3'd2, 3'd3: return pack(1, 0, 0, 1, 0, 0, bif.label11_in, 0, 0);
      3'd4: return pack(1, 0, 1, 0, 0, 0, 0, bif.rd_val, 0);
      3'd5: return pack(1, 0, 0, 0, 1, 0, 0, 0, bif.rm_val);
      3'd6: return (m_stack.size() > 0) ? pack(1, 0, 1, 0, 0, 0, 0, m_stack[$], 0) : '0;
      default: return '0;
    endcase
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_nzcv"}, 64'(bif.nzcv), 64'(m_nzcv));
    check({tag, "_cnt"},  64'(bif.ras_count), 64'(m_stack.size()));
    check({tag, "_ovf"},  64'(bif.ras_ovf), 64'(m_ovf));
    check({tag, "_unf"},  64'(bif.ras_unf), 64'(m_unf));
  endtask

  // Called just after a falling edge; returns the outputs seen for this instruction.
  task automatic apply(input bit en, input logic [2:0] op, input logic [3:0] cond,
                       input logic [7:0] d8, input logic [10:0] l11,
                       input logic [15:0] rd, input logic [15:0] rm, input logic [15:0] pc,
                       input bit we, input logic [3:0] nz, output logic [55:0] seen);
    bif.en = en; bif.op = op; bif.cond = cond; bif.disp8_in = d8; bif.label11_in = l11;
    bif.rd_val = rd; bif.rm_val = rm; bif.pc_q = pc; bif.flag_we = we; bif.nzcv_in = nz;
    #1;
    seen = dut_out();
    check("out", 64'(seen), 64'(exp_out()));
    check_state("pre");
    @(posedge clk);
    if (en && op == 3'd3) begin
      m_stack.push_back(pc + 16'd1);
      if (m_stack.size() > DEPTH) begin
        void'(m_stack.pop_front());
        m_ovf = 1'b1;
      end
    end else if (en && op == 3'd6) begin
      if (m_stack.size() > 0) void'(m_stack.pop_back());
      else m_unf = 1'b1;
    end
    if (we) m_nzcv = nz;
    @(negedge clk);
  endtask

  task automatic async_reset();
    bif.en = 1'b1; bif.op = 3'd3; bif.label11_in = 11'h7FF; bif.flag_we = 1'b1; bif.nzcv_in = 4'hF;
    #2;
    clr = 1'b0;
    m_rst = 1'b1;
    m_stack.delete();
    m_nzcv = '0; m_ovf = 1'b0; m_unf = 1'b0;
    #1;
    check("rst_out", 64'(dut_out()), 64'(0));
    check_state("rst");
    @(posedge clk);
    @(negedge clk);
    check_state("rst_hold");
    clr = 1'b1;
    m_rst = 1'b0;
  endtask

  logic [55:0] o;

  initial begin
    clr = 1'b0;
    m_rst = 1'b1;
    m_nzcv = '0; m_ovf = 1'b0; m_unf = 1'b0;
    bif.en = 1'b1; bif.op = 3'd2; bif.cond = '0; bif.disp8_in = 8'h12; bif.label11_in = 11'h55;
    bif.rd_val = '0; bif.rm_val = '0; bif.pc_q = '0; bif.flag_we = 1'b0; bif.nzcv_in = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_out", 64'(dut_out()), 64'(0));
    check_state("reset");
    clr = 1'b1;
    m_rst = 1'b0;

    // Same-cycle flag write must not affect this BCOND.
    apply(1, 3'd1, 4'd0, 8'd5, 0, 0, 0, 0, 1, 4'b0100, o);
    check("bcond_same_cycle", 64'(o), 64'(0));
    apply(1, 3'd1, 4'd0, 8'd5, 0, 0, 0, 0, 0, 0, o);
    check("bcond_eq_taken", 64'(o), 64'(pack(0, 1, 0, 0, 0, 8'd5, 0, 0, 0)));
    apply(1, 3'd1, 4'd1, 8'd5, 0, 0, 0, 0, 0, 0, o);
    check("bcond_ne_idle", 64'(o), 64'(0));

    apply(1, 3'd3, 0, 0, 11'd15, 0, 0, 16'h0010, 0, 0, o);
    check("bl_out", 64'(o), 64'(pack(1, 0, 0, 1, 0, 0, 11'd15, 0, 0)));
    check("bl_cnt", 64'(bif.ras_count), 64'(1));
    apply(1, 3'd6, 0, 0, 0, 0, 0, 0, 0, 0, o);
    check("ret_out", 64'(o), 64'(pack(1, 0, 1, 0, 0, 0, 0, 16'h0011, 0)));
    check("ret_cnt", 64'(bif.ras_count), 64'(0));

    apply(1, 3'd4, 0, 0, 0, 16'd20, 0, 0, 0, 0, o);
    check("bx_rd", 64'(o), 64'(pack(1, 0, 1, 0, 0, 0, 0, 16'd20, 0)));
    apply(1, 3'd5, 0, 0, 0, 0, 16'd50, 0, 0, 0, o);
    check("bx_rm", 64'(o), 64'(pack(1, 0, 0, 0, 1, 0, 0, 0, 16'd50)));

    for (int i = 1; i <= 9; i++) apply(1, 3'd3, 0, 0, 11'(i), 0, 0, 16'(i), 0, 0, o);
    check("ovf_sticky", 64'(bif.ras_ovf), 64'(1));
    check("ovf_cnt", 64'(bif.ras_count), 64'(DEPTH));
    for (int i = 0; i < 8; i++) begin
      apply(1, 3'd6, 0, 0, 0, 0, 0, 0, 0, 0, o);
      check("ret_seq", 64'(o[31:16]), 64'(10 - i));
    end
    apply(1, 3'd6, 0, 0, 0, 0, 0, 0, 0, 0, o);
    check("ret_empty_idle", 64'(o), 64'(0));
    check("unf_sticky", 64'(bif.ras_unf), 64'(1));

    apply(1, 3'd3, 0, 0, 11'd1, 0, 0, 16'hFFFF, 0, 0, o);
    apply(1, 3'd6, 0, 0, 0, 0, 0, 0, 0, 0, o);
    check("ret_wrap", 64'(o[31:16]), 64'(0));
    for (int i = 0; i < 3; i++) apply(1, 3'd3, 0, 0, 0, 0, 0, 16'h0100, 0, 0, o);
    check("pre_rst_cnt", 64'(bif.ras_count), 64'(3));
    async_reset();
    apply(1, 3'd6, 0, 0, 0, 0, 0, 0, 0, 0, o);
    check("post_rst_ret_idle", 64'(o), 64'(0));

    // en=0 still honours flag writes but must not touch the stack.
    apply(0, 3'd3, 0, 0, 11'd3, 0, 0, 16'h0040, 1, 4'b1001, o);
    check("en0_idle", 64'(o), 64'(0));
    check("en0_nzcv", 64'(bif.nzcv), 64'(4'b1001));

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
      end else begin
        apply($urandom_range(0, 9) != 0, 3'($urandom_range(0, 7)), 4'($urandom),
              8'($urandom), 11'($urandom), 16'($urandom), 16'($urandom),
              ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom),
              $urandom_range(0, 2) == 0, 4'($urandom), o);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
